ahb_slave_mem: RTL and testbench

AHB slave-side SRAM model and controller. It sits directly downstream of the slave interface and consumes the address/control/write-data phases a master drives through the bus. It returns hrdata, hreadyout and hresp with a configurable number of wait states and a two-cycle ERROR response. Bench masters use it as the default memory target, and it serves as the reference slave for protocol assertions.

---
 rtl/ahb_slave_mem.sv | 141 ++++++++++++++
 tb/tb_ahb_slave_mem.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_mem.sv
// AHB slave SRAM: single-port word array behind an AHB data-phase controller
// with configurable OKAY wait states and a two-cycle ERROR response.
module ahb_slave_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic [1:0]            hresp,
  output logic [DATA_WIDTH-1:0] hrdata
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int LANE_W = $clog2(BYTES);
  localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int PA_W   = LANE_W + IDX_W;
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH * BYTES);
  localparam logic [2:0] MAX_SIZE = 3'(LANE_W);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              vld_p1;
  logic              write_p1;
  logic [2:0]        size_p1;
  logic [PA_W-1:0]   addr_p1;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic              accept, open_slot, take, bad, commit;
  logic [IDX_W-1:0]  idx_p1;
  logic [BYTES-1:0]  mask_p1;
  logic              unused;

  function automatic logic misaligned(input logic [2:0] size, input logic [2:0] low);
    case (size)
      3'd0:    return 1'b0;
      3'd1:    return low[0];
      3'd2:    return |low[1:0];
      default: return |low;
    endcase
  endfunction

  // Bytes sharing the naturally aligned 2^size group that contains the offset.
  function automatic logic [BYTES-1:0] lane_mask(input logic [2:0] size,
                                                 input logic [LANE_W-1:0] off);
    logic [BYTES-1:0] m;
    m = '0;
    for (int b = 0; b < BYTES; b++) begin
      if ((b >> size) == (int'(off) >> size)) m[b] = 1'b1;
    end
    return m;
  endfunction

  assign unused    = &{1'b0, hburst, htrans[0]};
  assign accept    = hsel & hready & htrans[1];
  assign open_slot = (state == S_IDLE) || (state == S_ERR2);
  assign take      = accept & open_slot;
  assign bad       = ({1'b0, haddr} >= MEM_BYTES) | (hsize > MAX_SIZE) |
                     misaligned(hsize, haddr[2:0]);
  assign commit    = vld_p1 & (state == S_IDLE);
  assign idx_p1    = addr_p1[PA_W-1:LANE_W];
  assign mask_p1   = lane_mask(size_p1, addr_p1[LANE_W-1:0]);

  // Stage p0 -> p1: address phase capture and data-phase sequencing
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state    <= S_IDLE;
      cnt      <= '0;
      vld_p1   <= 1'b0;
      write_p1 <= 1'b0;
      size_p1  <= '0;
      addr_p1  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (take) begin
        vld_p1   <= ~bad;
        write_p1 <= hwrite;
        size_p1  <= hsize;
        addr_p1  <= haddr[PA_W-1:0];
      end else if (commit) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE, S_ERR2: begin
        state_nxt = S_IDLE;
        if (take) begin
          if (bad) begin
            state_nxt = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_nxt = S_WAIT;
            cnt_nxt   = 4'(WAIT_STATES);
          end
        end
      end
      S_WAIT: begin
        if (cnt <= 4'd1) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_ERR1:  state_nxt = S_ERR2;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign hreadyout = (state != S_WAIT) && (state != S_ERR1);
  assign hresp     = ((state == S_ERR1) || (state == S_ERR2)) ? 2'b01 : 2'b00;

  // Stage p1: array access; writes land on the completing edge only
  always_ff @(posedge hclk) begin
    if (commit && write_p1) begin
      for (int b = 0; b < BYTES; b++) begin
        if (mask_p1[b]) mem[idx_p1][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  assign hrdata = (vld_p1 && !write_p1) ? mem[idx_p1] : '0;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Randomized bench: two slaves (0 and 3 wait states) each driven by an AHB
// master task; a transaction-level model predicts every data-phase cycle.
module tb_ahb_slave_mem;

  typedef struct packed {
    logic        rdy;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  burst;
  } item_t;

  localparam exp_t IDLE_EXP = {1'b1, 2'b00, 32'h0};
  localparam int   MEM_BYTES = 1024;

  logic        hclk;
  logic        hresetn;
  logic        sel_a   [2];
  logic [31:0] addr_a  [2];
  logic [1:0]  trans_a [2];
  logic        wr_a    [2];
  logic [2:0]  size_a  [2];
  logic [2:0]  burst_a [2];
  logic [31:0] wdata_a [2];
  logic        rdy_a   [2];
  logic [1:0]  resp_a  [2];
  logic [31:0] rdata_a [2];

  int          ncmp;
  int          nfail;
  logic        chk_en  [2];
  logic [31:0] pend    [2];
  logic [7:0]  mb      [2][MEM_BYTES];
  exp_t        q0[$];
  exp_t        q1[$];
  int          ws_of   [2];

  ahb_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
    .hclk(hclk), .hresetn(hresetn), .hsel(sel_a[0]), .haddr(addr_a[0]),
    .htrans(trans_a[0]), .hwrite(wr_a[0]), .hsize(size_a[0]), .hburst(burst_a[0]),
    .hwdata(wdata_a[0]), .hready(rdy_a[0]), .hreadyout(rdy_a[0]),
    .hresp(resp_a[0]), .hrdata(rdata_a[0]));

  ahb_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(3)) dut3 (
    .hclk(hclk), .hresetn(hresetn), .hsel(sel_a[1]), .haddr(addr_a[1]),
    .htrans(trans_a[1]), .hwrite(wr_a[1]), .hsize(size_a[1]), .hburst(burst_a[1]),
    .hwdata(wdata_a[1]), .hready(rdy_a[1]), .hreadyout(rdy_a[1]),
    .hresp(resp_a[1]), .hrdata(rdata_a[1]));

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  function automatic item_t mk(logic sel, logic [1:0] trans, logic wr, logic [2:0] size,
                               logic [31:0] addr, logic [31:0] data);
    item_t it;
    it.sel = sel; it.trans = trans; it.wr = wr; it.size = size;
    it.addr = addr; it.data = data; it.burst = 3'b000;
    return it;
  endfunction

  function automatic logic is_err(item_t it);
    int n;
    n = 1 << it.size;
    return (it.addr >= 32'(MEM_BYTES)) || (it.size > 3'd2) || ((it.addr % 32'(n)) != 0);
  endfunction

  function automatic logic [31:0] mword(int d, logic [31:0] a);
    logic [31:0] w;
    int b0;
    b0 = int'(a & 32'hFFFF_FFFC);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = mb[d][b0 + i];
    return w;
  endfunction

  function automatic void mwrite(int d, logic [31:0] a, logic [2:0] size, logic [31:0] data);
    int ba;
    for (int i = 0; i < (1 << size); i++) begin
      ba = int'(a) + i;
      mb[d][ba] = data[8*(ba % 4) +: 8];
    end
  endfunction

  function automatic void push(int d, exp_t e);
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endfunction

  task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare_loop();
    exp_t e, act;
    forever begin
      @(negedge hclk);
      for (int d = 0; d < 2; d++) begin
        if (chk_en[d]) begin
          e = IDLE_EXP;
          if (d == 0 && q0.size() > 0) e = q0.pop_front();
          else if (d == 1 && q1.size() > 0) e = q1.pop_front();
          act = {rdy_a[d], resp_a[d], rdata_a[d]};
          ncmp++;
          if (act !== e) begin
            nfail++;
            $display("FAIL bus%0d t=%0t: got rdy=%b resp=%b data=%h expected rdy=%b resp=%b data=%h",
                     d, $time, act.rdy, act.resp, act.data, e.rdy, e.resp, e.data);
          end
        end
      end
    end
  endtask

  // Presents one address phase (while the previous data phase runs) and
  // returns once the edge that samples it has passed; waits = low cycles seen.
  task automatic do_item(int d, item_t it, output int waits);
    logic [31:0] rd;
    sel_a[d] = it.sel; trans_a[d] = it.trans; wr_a[d] = it.wr;
    size_a[d] = it.size; addr_a[d] = it.addr; burst_a[d] = it.burst;
    wdata_a[d] = pend[d];
    waits = 0;
    @(negedge hclk);
    while (!rdy_a[d] && waits < 50) begin
      waits++;
      @(negedge hclk);
    end
    if (waits >= 50) begin
      ncmp++; nfail++;
      $display("FAIL bus%0d timeout waiting for hreadyout", d);
    end
    @(posedge hclk);
    #1;
    pend[d] = $urandom;
    if (it.sel && it.trans[1]) begin
      if (is_err(it)) begin
        push(d, {1'b0, 2'b01, 32'h0});
        push(d, {1'b1, 2'b01, 32'h0});
      end else begin
        rd = it.wr ? 32'h0 : mword(d, it.addr);
        if (it.wr) begin
          mwrite(d, it.addr, it.size, it.data);
          pend[d] = it.data;
        end
        for (int i = 0; i < ws_of[d]; i++) push(d, {1'b0, 2'b00, rd});
        push(d, {1'b1, 2'b00, rd});
      end
    end
  endtask

  task automatic run(int d, item_t it);
    int w;
    do_item(d, it, w);
  endtask

  function automatic item_t rand_item();
    item_t it;
    int k, s;
    k = $urandom_range(0, 99);
    it = mk(1'b1, 2'b10, 1'($urandom_range(0, 1)), 3'd2, 32'h0, $urandom);
    if (k < 8) it.trans = 2'b00;
    else if (k < 13) it.trans = 2'b01;
    else if (k < 17) it.sel = 1'b0;
    else if (k < 21) it.addr = 32'h400 + 32'($urandom_range(0, 255)) * 4;
    else if (k < 25) begin it.size = 3'd1; it.addr = 32'($urandom_range(0, 127)) * 2 + 1; end
    else if (k < 28) begin it.size = 3'd3; it.addr = 32'($urandom_range(0, 31)) * 8; end
    else begin
      s = $urandom_range(0, 2);
      it.size = 3'(s);
      it.addr = 32'($urandom_range(0, 255)) & ~((32'd1 << s) - 1);
      if (k % 2 == 1) it.trans = 2'b11;
    end
    return it;
  endfunction

  initial begin
    int w;
    item_t it;
    ncmp = 0; nfail = 0;
    ws_of[0] = 0; ws_of[1] = 3;
    hresetn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk_en[d] = 1'b1; pend[d] = 32'h0;
      sel_a[d] = 1'b0; trans_a[d] = 2'b00; wr_a[d] = 1'b0; size_a[d] = 3'd0;
      addr_a[d] = 32'h0; burst_a[d] = 3'd0; wdata_a[d] = 32'h0;
    end
    fork compare_loop(); join_none
    #12;
    for (int d = 0; d < 2; d++) begin
      check32("reset_hreadyout", 32'(rdy_a[d]), 32'h1);
      check32("reset_hresp", 32'(resp_a[d]), 32'h0);
      check32("reset_hrdata", rdata_a[d], 32'h0);
    end
    #10 hresetn = 1'b1;
    @(posedge hclk); #1;

    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 256; a += 4) run(d, mk(1, 2'b10, 1, 3'd2, 32'(a), $urandom));
    for (int d = 0; d < 2; d++) run(d, mk(1, 2'b00, 0, 3'd2, 0, 0));

    // Write then read back at zero wait states
    run(0, mk(1, 2'b10, 1, 3'd2, 32'h10, 32'hDEADBEEF));
    do_item(0, mk(1, 2'b10, 0, 3'd2, 32'h10, 0), w);
    check32("ws0_write_wait", 32'(w), 32'h0);
    check32("model_deadbeef", mword(0, 32'h10), 32'hDEADBEEF);
    run(0, mk(1, 2'b10, 1, 3'd2, 32'h10, 32'h11223344));
    run(0, mk(1, 2'b10, 1, 3'd0, 32'h13, 32'hAA000000));
    run(0, mk(1, 2'b10, 0, 3'd2, 32'h10, 0));
    check32("model_byte_merge", mword(0, 32'h10), 32'hAA223344);
    run(0, mk(1, 2'b10, 0, 3'd2, 32'h400, 0));
    run(0, mk(1, 2'b10, 1, 3'd1, 32'h01, 32'hFFFFFFFF));
    run(0, mk(1, 2'b10, 0, 3'd2, 32'h00, 0));
    run(0, mk(1, 2'b00, 0, 3'd2, 32'h44, 0));
    run(0, mk(1, 2'b01, 1, 3'd2, 32'h48, 0));
    for (int i = 0; i < 4; i++) begin
      it = mk(1, (i == 0) ? 2'b10 : 2'b11, 1, 3'd2, 32'h40 + 32'(4*i), 32'hC0DE0000 + 32'(i));
      it.burst = 3'b001;
      run(0, it);
    end
    for (int i = 0; i < 4; i++) begin
      it = mk(1, (i == 0) ? 2'b10 : 2'b11, 0, 3'd2, 32'h40 + 32'(4*i), 0);
      it.burst = 3'b001;
      run(0, it);
    end
    check32("model_burst_last", mword(0, 32'h4C), 32'hC0DE0003);
    for (int i = 0; i < 200; i++) run(0, rand_item());
    run(0, mk(1, 2'b00, 0, 3'd2, 0, 0));

    // Three wait states: one read, then count the low cycles
    run(1, mk(1, 2'b10, 0, 3'd2, 32'h10, 0));
    do_item(1, mk(1, 2'b00, 0, 3'd2, 0, 0), w);
    check32("ws3_low_cycles", 32'(w), 32'h3);
    run(1, mk(1, 2'b10, 1, 3'd2, 32'h20, 32'h5A5A0020));
    run(1, mk(1, 2'b00, 0, 3'd2, 0, 0));

    // Reset in the middle of a waited write
    chk_en[1] = 1'b0;
    sel_a[1] = 1'b1; trans_a[1] = 2'b10; wr_a[1] = 1'b1; size_a[1] = 3'd2; addr_a[1] = 32'h20;
    @(posedge hclk); #1;
    trans_a[1] = 2'b00; wdata_a[1] = 32'h12345678;
    @(negedge hclk);
    check32("mid_wait_hreadyout", 32'(rdy_a[1]), 32'h0);
    #2 hresetn = 1'b0;
    #1;
    check32("async_rst_hreadyout", 32'(rdy_a[1]), 32'h1);
    check32("async_rst_hresp", 32'(resp_a[1]), 32'h0);
    check32("async_rst_hrdata", rdata_a[1], 32'h0);
    @(negedge hclk) hresetn = 1'b1;
    @(posedge hclk); #1;
    chk_en[1] = 1'b1;
    pend[1] = 32'h0;
    run(1, mk(1, 2'b10, 0, 3'd2, 32'h20, 0));
    check32("model_prewrite_kept", mword(1, 32'h20), 32'h5A5A0020);
    for (int i = 0; i < 200; i++) run(1, rand_item());
    run(1, mk(1, 2'b00, 0, 3'd2, 0, 0));

    repeat (4) @(posedge hclk);
    #1;
    check32("queue0_drained", 32'(q0.size()), 32'h0);
    check32("queue1_drained", 32'(q1.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
